// File: rtl/apb_slave_regbank.sv
// APB slave register bank: DEPTH x 32-bit words decoded from a PADDR window,
// WAIT_CYCLES wait states via PREADY, and PSLVERR for out-of-window accesses.
module apb_slave_regbank #(
    parameter logic [31:0] BASE_ADDR   = 32'd1,
    parameter int          DEPTH       = 10,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LAST_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH) - 33'd1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             write_q;
    logic             in_win_q;
    logic [31:0]      wdata_q;
    logic [31:0]      prdata_q;
    logic             pready_q;
    logic             pslverr_q;
    logic [31:0]      mem_q [DEPTH];

    logic             in_win_d;
    logic [IDX_W-1:0] idx_d;
    logic [31:0]      setup_rdata_d;
    logic [31:0]      access_rdata_d;

    // The 33-bit upper compare keeps a window near the top of the address
    // space from wrapping around.
    always_comb begin
        in_win_d       = (PADDR >= BASE_ADDR) && ({1'b0, PADDR} <= LAST_ADDR);
        idx_d          = IDX_W'(PADDR - BASE_ADDR);
        setup_rdata_d  = (in_win_d && !PWRITE) ? mem_q[idx_d] : '0;
        access_rdata_d = (in_win_q && !write_q) ? mem_q[idx_q] : '0;
    end

    // NOTE: all state here is sequential, so every assignment in this block
    // is non-blocking; mixing in blocking writes would create ordering races.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            in_win_q  <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            // NOTE: the word array is cleared by reset, so it maps to flops
            // rather than a RAM macro; acceptable at register-bank depths.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (PSEL && !PENABLE) begin
            // Setup phase, either from IDLE or as a restart out of ACCESS.
            state_q   <= ACCESS;
            cnt_q     <= WAIT_INIT;
            idx_q     <= idx_d;
            write_q   <= PWRITE;
            in_win_q  <= in_win_d;
            wdata_q   <= PWDATA;
            pready_q  <= (WAIT_CYCLES == 0);
            pslverr_q <= (WAIT_CYCLES == 0) && !in_win_d;
            prdata_q  <= (WAIT_CYCLES == 0) ? setup_rdata_d : '0;
        end else if (state_q == ACCESS) begin
            if (!PSEL) begin
                state_q   <= IDLE;
                pready_q  <= 1'b0;
                pslverr_q <= 1'b0;
                prdata_q  <= '0;
            end else if (pready_q) begin
                if (write_q && in_win_q) begin
                    mem_q[idx_q] <= wdata_q;
                end
                state_q   <= IDLE;
                pready_q  <= 1'b0;
                pslverr_q <= 1'b0;
                prdata_q  <= '0;
            end else begin
                cnt_q <= cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    pready_q  <= 1'b1;
                    pslverr_q <= !in_win_q;
                    prdata_q  <= access_rdata_d;
                end
            end
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Scoreboard bench for apb_slave_regbank: one instance with one wait state,
// one zero-wait instance, both with the default 1..10 window.
module tb_apb_slave_regbank;

    localparam logic [31:0] BASE  = 32'd1;
    localparam int          DEPTH = 10;
    localparam int          W0    = 1;
    localparam int          W1    = 0;

    typedef struct {
        int          slv;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    logic [31:0] model_mem [2][DEPTH];
    exp_t        sb_q [$];
    int          n_tests;
    int          n_fail;

    apb_slave_regbank #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(W0)) u_dut_w1 (
        .PCLK   (clk),
        .PRESETn(rst_n),
        .PSEL   (psel[0]),
        .PENABLE(penable[0]),
        .PWRITE (pwrite[0]),
        .PADDR  (paddr[0]),
        .PWDATA (pwdata[0]),
        .PRDATA (prdata[0]),
        .PREADY (pready[0]),
        .PSLVERR(pslverr[0])
    );

    apb_slave_regbank #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(W1)) u_dut_w0 (
        .PCLK   (clk),
        .PRESETn(rst_n),
        .PSEL   (psel[1]),
        .PENABLE(penable[1]),
        .PWRITE (pwrite[1]),
        .PADDR  (paddr[1]),
        .PWDATA (pwdata[1]),
        .PRDATA (prdata[1]),
        .PREADY (pready[1]),
        .PSLVERR(pslverr[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                model_mem[s][i] = '0;
            end
        end
    endtask

    task automatic go_idle(input int s);
        @(negedge clk);
        psel[s]    = 1'b0;
        penable[s] = 1'b0;
    endtask

    task automatic check_outputs_zero(input int s, input string tag);
        check({tag, "_pready"}, 32'(pready[s]), 32'd0);
        check({tag, "_pslverr"}, 32'(pslverr[s]), 32'd0);
        check({tag, "_prdata"}, prdata[s], 32'd0);
    endtask

    // One full APB transfer; the bus is left in the completing cycle so a
    // following call issues its setup back-to-back.
    task automatic transfer(input int s, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input string tag);
        exp_t e;
        int   cycles;
        logic win;
        win     = (addr >= BASE) && (addr <= BASE + DEPTH - 1);
        e.slv   = s;
        e.err   = !win;
        e.rdata = '0;
        if (wr && win) model_mem[s][addr - BASE] = data;
        if (!wr && win) e.rdata = model_mem[s][addr - BASE];
        sb_q.push_back(e);

        @(negedge clk);
        psel[s]    = 1'b1;
        penable[s] = 1'b0;
        pwrite[s]  = wr;
        paddr[s]   = addr;
        pwdata[s]  = data;
        @(negedge clk);
        penable[s] = 1'b1;
        paddr[s]   = ~addr;
        pwdata[s]  = ~data;
        cycles = 1;
        while (!pready[s] && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end

        e = sb_q.pop_front();
        check({tag, "_ready"}, 32'(pready[s]), 32'd1);
        check({tag, "_latency"}, 32'(cycles), 32'(((e.slv == 0) ? W0 : W1) + 1));
        check({tag, "_rdata"}, prdata[s], e.rdata);
        check({tag, "_pslverr"}, 32'(pslverr[s]), 32'(e.err));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_model();
        for (int s = 0; s < 2; s++) begin
            psel[s]    = 1'b0;
            penable[s] = 1'b0;
            pwrite[s]  = 1'b0;
            paddr[s]   = '0;
            pwdata[s]  = '0;
        end

        // Reset held for two edges; every word reads back as zero.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero(0, "reset_w1");
        check_outputs_zero(1, "reset_w0");
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            transfer(0, 1'b0, BASE + 32'(i), 32'd0, $sformatf("reset_rd%0d", i));
        end

        // One wait state: write then read back.
        transfer(0, 1'b1, 32'd3, 32'hDEAD_BEEF, "w1_wr3");
        transfer(0, 1'b0, 32'd3, 32'd0, "w1_rd3");

        // Window edges and out-of-window accesses.
        transfer(0, 1'b1, 32'd10, 32'h1234_5678, "edge_wr10");
        transfer(0, 1'b1, 32'd0, 32'hFFFF_0000, "edge_wr0");
        transfer(0, 1'b1, 32'd11, 32'h0BAD_0BAD, "edge_wr11");
        transfer(0, 1'b0, 32'd11, 32'd0, "edge_rd11");
        transfer(0, 1'b0, 32'hFFFF_FFFF, 32'd0, "edge_rdmax");
        transfer(0, 1'b0, 32'd10, 32'd0, "edge_rd10");
        transfer(0, 1'b0, 32'd1, 32'd0, "edge_rd1");
        go_idle(0);

        // Zero-wait back-to-back write/read.
        transfer(1, 1'b1, 32'd5, 32'h0000_0001, "w0_wr5");
        transfer(1, 1'b0, 32'd5, 32'd0, "w0_rd5");
        transfer(1, 1'b0, 32'd0, 32'd0, "w0_rd0");
        go_idle(1);

        // Abort: PSEL dropped in the first access cycle, before PREADY.
        @(negedge clk);
        psel[0]    = 1'b1;
        penable[0] = 1'b0;
        pwrite[0]  = 1'b1;
        paddr[0]   = 32'd7;
        pwdata[0]  = 32'h0000_00AA;
        @(negedge clk);
        check("abort_pre_pready", 32'(pready[0]), 32'd0);
        psel[0] = 1'b0;
        @(negedge clk);
        check_outputs_zero(0, "abort");
        transfer(0, 1'b0, 32'd7, 32'd0, "abort_rd7");
        go_idle(0);

        // Reset in the middle of an access; no write commits, bank is cleared.
        @(negedge clk);
        psel[0]    = 1'b1;
        penable[0] = 1'b0;
        pwrite[0]  = 1'b1;
        paddr[0]   = 32'd2;
        pwdata[0]  = 32'h0000_0055;
        @(negedge clk);
        penable[0] = 1'b1;
        rst_n      = 1'b0;
        @(negedge clk);
        check_outputs_zero(0, "midrst");
        psel[0]    = 1'b0;
        penable[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        transfer(0, 1'b0, 32'd2, 32'd0, "midrst_rd2");
        transfer(0, 1'b0, 32'd3, 32'd0, "midrst_rd3");
        go_idle(0);

        // Random mixed traffic on both instances, addresses straddling the window.
        for (int n = 0; n < 24; n++) begin
            int s;
            s = int'($urandom_range(1, 0));
            transfer(s, 1'($urandom_range(1, 0)), 32'($urandom_range(12, 0)),
                     $urandom, $sformatf("rand%0d", n));
            if ($urandom_range(3, 0) == 0) go_idle(s);
        end
        go_idle(0);
        go_idle(1);
        for (int i = 0; i < DEPTH; i++) begin
            transfer(0, 1'b0, BASE + 32'(i), 32'd0, $sformatf("final_w1_rd%0d", i));
            transfer(1, 1'b0, BASE + 32'(i), 32'd0, $sformatf("final_w0_rd%0d", i));
        end
        go_idle(0);
        go_idle(1);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
